// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared definitions for the register/RAM block: bus widths, the word-address
// map (base addresses and field widths) and the address decoder used by the
// write path and the read pipeline.
// Contents:
//   ADDR_W / DATA_W   bus address and data widths
//   *_ADDR / *_BASE   word addresses of registers and RAM windows
//   *_W               field widths
//   region_e          decoded region of an address
//   decode_t          region plus copy index
//   decodeAddr()      full 24-bit decode, aware of how many foo copies exist
// -----------------------------------------------------------------------------
package top_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    localparam int MAX_COPIES = 4;

    localparam logic [ADDR_W-1:0] TOP_REG_ADDR = 24'h00_0000;
    localparam logic [ADDR_W-1:0] TOP_BAZ_ADDR = 24'h00_0001;
    localparam logic [ADDR_W-1:0] FOO_N_BASE   = 24'h00_0004;
    localparam logic [ADDR_W-1:0] BAZ_RAM_BASE = 24'h00_0008;
    localparam logic [ADDR_W-1:0] FOO_RAM_BASE = 24'h00_0020;

    localparam int TOP_REG_W      = 8;
    localparam int TOP_BAZ_W      = 4;
    localparam int FOO_N_W        = 4;
    localparam int RAM_W          = 8;
    localparam int RAM_DEPTH      = 8;
    localparam int RAM_AW         = 3;
    localparam int FOO_RAM_STRIDE = 8;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_TOP_REG,
        RGN_TOP_BAZ,
        RGN_FOO_N,
        RGN_BAZ_RAM,
        RGN_FOO_RAM
    } region_e;

    typedef struct packed {
        region_e    region;
        logic [1:0] idx;
    } decode_t;

    // All 24 address bits take part in every comparison, so nothing aliases.
    // Copies at or beyond 'copies' are treated as unmapped.
    function automatic decode_t decodeAddr(input logic [ADDR_W-1:0] addr,
                                           input int copies);
        decode_t d;
        d.region = RGN_NONE;
        d.idx    = '0;
        if (addr == TOP_REG_ADDR) begin
            d.region = RGN_TOP_REG;
        end else if (addr == TOP_BAZ_ADDR) begin
            d.region = RGN_TOP_BAZ;
        end else if (addr[ADDR_W-1:2] == FOO_N_BASE[ADDR_W-1:2] &&
                     int'({30'd0, addr[1:0]}) < copies) begin
            d.region = RGN_FOO_N;
            d.idx    = addr[1:0];
        end else if (addr[ADDR_W-1:RAM_AW] == BAZ_RAM_BASE[ADDR_W-1:RAM_AW]) begin
            d.region = RGN_BAZ_RAM;
        end else if (addr[ADDR_W-1:5] == FOO_RAM_BASE[ADDR_W-1:5] &&
                     int'({30'd0, addr[4:3]}) < copies) begin
            d.region = RGN_FOO_RAM;
            d.idx    = addr[4:3];
        end
        return d;
    endfunction

endpackage

// File: rtl/foo_blk.sv
// -----------------------------------------------------------------------------
// foo_blk
// One 8 x 8 RAM window that decodes its own slice of the word-address space.
// Writes land on the clock edge where we_i is high and the address falls in
// the window; reads are synchronous and read-first, so a read and a write to
// the same entry on the same edge returns the old contents. The read register
// only updates on a read hit, so it holds its value while the rest of the
// read pipeline catches up. No reset on the storage so it maps onto RAM.
// Ports:
//   clk_i    bus clock
//   we_i     write enable (already qualified by the top)
//   re_i     read enable (already qualified by the top)
//   addr_i   full word address
//   wdata_i  write data, already truncated to the entry width
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module foo_blk
    import top_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE = BAZ_RAM_BASE
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [RAM_W-1:0]  wdata_i,
    output logic [RAM_W-1:0]  rdata_o
);

    logic                 hit;
    logic [RAM_W-1:0]     mem_q [RAM_DEPTH];
    logic [RAM_W-1:0]     rdata_q;

    assign hit = (addr_i[ADDR_W-1:RAM_AW] == BASE[ADDR_W-1:RAM_AW]);

    // Read-first storage: the read samples the array before this edge's write.
    always_ff @(posedge clk_i) begin
        if (we_i && hit) begin
            mem_q[addr_i[RAM_AW-1:0]] <= wdata_i;
        end
        if (re_i && hit) begin
            rdata_q <= mem_q[addr_i[RAM_AW-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// Word-addressed register/RAM block: top_reg, top_baz, FOO_COPIES foo nibble
// registers, one baz RAM and FOO_COPIES foo RAMs. Reads complete exactly two
// cycles after the strobe and gb_rdata holds until the next read completes.
// Parameters:
//   FOO_COPIES  number of foo register + RAM pairs (1..4)
//   TOP_BAZ     reset value of top_baz (low 4 bits)
// Ports:
//   gb_clk    bus clock, rising edge
//   gb_rst_n  asynchronous active-low reset
//   gb_addr   word address
//   gb_wdata  write data
//   gb_rdata  read data
//   gb_wen    write strobe
//   gb_rstb   read strobe
// -----------------------------------------------------------------------------
module top
    import top_pkg::*;
#(
    parameter int FOO_COPIES = 4,
    parameter int TOP_BAZ    = 1
) (
    input  logic              gb_clk,
    input  logic              gb_rst_n,
    input  logic [ADDR_W-1:0] gb_addr,
    input  logic [DATA_W-1:0] gb_wdata,
    output logic [DATA_W-1:0] gb_rdata,
    input  logic              gb_wen,
    input  logic              gb_rstb
);

    localparam logic [31:0] TOP_BAZ_VEC = TOP_BAZ;

    logic [1:0]           rstSync_q;
    logic                 accessOk;
    logic                 wrEn;
    logic                 rdEn;
    decode_t              dec;

    logic [TOP_REG_W-1:0] topReg_q;
    logic [TOP_BAZ_W-1:0] topBaz_q;
    logic [FOO_N_W-1:0]   fooN_q [FOO_COPIES];

    logic [RAM_W-1:0]     bazRd;
    logic [RAM_W-1:0]     fooRd [FOO_COPIES];

    logic [7:0]           snap_d;
    logic                 rd1Vld_q;
    region_e              rd1Rgn_q;
    logic [1:0]           rd1Idx_q;
    logic [7:0]           rd1Snap_q;

    logic [DATA_W-1:0]    mux_d;
    logic                 rd2Vld_q;
    logic [DATA_W-1:0]    rd2Data_q;
    logic [DATA_W-1:0]    rdata_q;

    logic                 unusedWdata;

    assign unusedWdata = ^gb_wdata[DATA_W-1:RAM_W];

    // Reset release is brought into the clock domain; bus accesses are
    // ignored until the release has crossed both stages.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign accessOk = rstSync_q[1];
    assign wrEn     = gb_wen  && accessOk;
    assign rdEn     = gb_rstb && accessOk;
    assign dec      = decodeAddr(gb_addr, FOO_COPIES);

    // Control registers, written directly from the bus.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            topReg_q <= '0;
            topBaz_q <= TOP_BAZ_VEC[TOP_BAZ_W-1:0];
            for (int k = 0; k < FOO_COPIES; k++) begin
                fooN_q[k] <= '0;
            end
        end else if (wrEn) begin
            case (dec.region)
                RGN_TOP_REG: topReg_q <= gb_wdata[TOP_REG_W-1:0];
                RGN_TOP_BAZ: topBaz_q <= gb_wdata[TOP_BAZ_W-1:0];
                RGN_FOO_N: begin
                    for (int k = 0; k < FOO_COPIES; k++) begin
                        if (dec.idx == 2'(k)) begin
                            fooN_q[k] <= gb_wdata[FOO_N_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    foo_blk #(
        .BASE (BAZ_RAM_BASE)
    ) u_bazRam (
        .clk_i   (gb_clk),
        .we_i    (wrEn),
        .re_i    (rdEn),
        .addr_i  (gb_addr),
        .wdata_i (gb_wdata[RAM_W-1:0]),
        .rdata_o (bazRd)
    );

    for (genvar k = 0; k < FOO_COPIES; k++) begin : g_fooRam
        foo_blk #(
            .BASE (FOO_RAM_BASE + ADDR_W'(FOO_RAM_STRIDE * k))
        ) u_fooRam (
            .clk_i   (gb_clk),
            .we_i    (wrEn),
            .re_i    (rdEn),
            .addr_i  (gb_addr),
            .wdata_i (gb_wdata[RAM_W-1:0]),
            .rdata_o (fooRd[k])
        );
    end

    // Register values are snapshotted on the strobe edge, alongside the RAM
    // read, so a write on the same or the following edge cannot leak in.
    always_comb begin
        snap_d = '0;
        case (dec.region)
            RGN_TOP_REG: snap_d = topReg_q;
            RGN_TOP_BAZ: snap_d = {4'b0000, topBaz_q};
            RGN_FOO_N: begin
                for (int k = 0; k < FOO_COPIES; k++) begin
                    if (dec.idx == 2'(k)) begin
                        snap_d = {4'b0000, fooN_q[k]};
                    end
                end
            end
            default: ;
        endcase
    end

    // First read stage: remember which region was addressed.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            rd1Vld_q  <= 1'b0;
            rd1Rgn_q  <= RGN_NONE;
            rd1Idx_q  <= '0;
            rd1Snap_q <= '0;
        end else begin
            rd1Vld_q <= rdEn;
            if (rdEn) begin
                rd1Rgn_q  <= dec.region;
                rd1Idx_q  <= dec.idx;
                rd1Snap_q <= snap_d;
            end
        end
    end

    // The read mux: one case on the decoded region.
    always_comb begin
        mux_d = '0;
        case (rd1Rgn_q)
            RGN_TOP_REG,
            RGN_TOP_BAZ,
            RGN_FOO_N:   mux_d = DATA_W'(rd1Snap_q);
            RGN_BAZ_RAM: mux_d = DATA_W'(bazRd);
            RGN_FOO_RAM: begin
                for (int k = 0; k < FOO_COPIES; k++) begin
                    if (rd1Idx_q == 2'(k)) begin
                        mux_d = DATA_W'(fooRd[k]);
                    end
                end
            end
            default: mux_d = '0;
        endcase
    end

    // Second and output stages; gb_rdata only moves when a read completes.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            rd2Vld_q  <= 1'b0;
            rd2Data_q <= '0;
            rdata_q   <= '0;
        end else begin
            rd2Vld_q <= rd1Vld_q;
            if (rd1Vld_q) begin
                rd2Data_q <= mux_d;
            end
            if (rd2Vld_q) begin
                rdata_q <= rd2Data_q;
            end
        end
    end

    assign gb_rdata = rdata_q;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top
// Drives two copies of top (FOO_COPIES = 4 and FOO_COPIES = 2) from the same
// bus and compares both read-data outputs against an address-map model that
// stores field values per word address and masks them to the field width.
// -----------------------------------------------------------------------------
module tb_top;

    localparam int TOP_BAZ = 1;
    localparam int MDL_SIZE = 'h48;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [23:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wen = 1'b0;
    logic        rstb = 1'b0;
    logic [31:0] rdata4;
    logic [31:0] rdata2;

    int nChecks = 0;
    int nFails  = 0;

    // Model storage: [0] mirrors the 4-copy instance, [1] the 2-copy one.
    logic [31:0] mdl [2][MDL_SIZE];
    logic [23:0] aliasPool [5];

    always #5 clk = ~clk;

    top #(.FOO_COPIES(4), .TOP_BAZ(TOP_BAZ)) dut4 (
        .gb_clk   (clk),
        .gb_rst_n (rstN),
        .gb_addr  (addr),
        .gb_wdata (wdata),
        .gb_rdata (rdata4),
        .gb_wen   (wen),
        .gb_rstb  (rstb)
    );

    top #(.FOO_COPIES(2), .TOP_BAZ(TOP_BAZ)) dut2 (
        .gb_clk   (clk),
        .gb_rst_n (rstN),
        .gb_addr  (addr),
        .gb_wdata (wdata),
        .gb_rdata (rdata2),
        .gb_wen   (wen),
        .gb_rstb  (rstb)
    );

    // Width of the field living at word address a, 0 when unmapped.
    function automatic int fieldWidth(input logic [23:0] a, input int copies);
        int ai;
        ai = int'({8'd0, a});
        if (ai == 0) return 8;
        if (ai == 1) return 4;
        if (ai >= 4 && ai < 4 + copies) return 4;
        if (ai >= 8 && ai < 16) return 8;
        if (ai >= 32 && ai < 32 + 8 * copies) return 8;
        return 0;
    endfunction

    function automatic int copiesOf(input int which);
        return (which == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] modelRead(input int which, input logic [23:0] a);
        int w;
        w = fieldWidth(a, copiesOf(which));
        if (w == 0) return 32'h0;
        return mdl[which][int'({8'd0, a})] & ((32'h1 << w) - 32'h1);
    endfunction

    task automatic modelWrite(input logic [23:0] a, input logic [31:0] d);
        int w;
        for (int which = 0; which < 2; which++) begin
            w = fieldWidth(a, copiesOf(which));
            if (w != 0) begin
                mdl[which][int'({8'd0, a})] = d & ((32'h1 << w) - 32'h1);
            end
        end
    endtask

    // Registers return to reset values; RAM contents survive.
    task automatic modelReset();
        for (int which = 0; which < 2; which++) begin
            mdl[which][0] = 32'h0;
            mdl[which][1] = TOP_BAZ & 32'hF;
            for (int a = 4; a < 8; a++) mdl[which][a] = 32'h0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one bus cycle starting at a falling edge and returns on the next one.
    task automatic applyStimulus(input logic w, input logic r, input logic [23:0] a,
                                 input logic [31:0] d);
        wen   = w;
        rstb  = r;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wen  = 1'b0;
        rstb = 1'b0;
    endtask

    task automatic busWrite(input logic [23:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
        modelWrite(a, d);
    endtask

    task automatic busRead(input string pfx, input logic [23:0] a);
        logic [31:0] e4;
        logic [31:0] e2;
        e4 = modelRead(0, a);
        e2 = modelRead(1, a);
        applyStimulus(1'b0, 1'b1, a, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput($sformatf("%s_c4@%06h", pfx, a), rdata4, e4);
        checkOutput($sformatf("%s_c2@%06h", pfx, a), rdata2, e2);
    endtask

    // Read and write strobed together: the read sees the old value.
    task automatic readWriteSame(input string pfx, input logic [23:0] a, input logic [31:0] d);
        logic [31:0] e4;
        logic [31:0] e2;
        e4 = modelRead(0, a);
        e2 = modelRead(1, a);
        applyStimulus(1'b1, 1'b1, a, d);
        modelWrite(a, d);
        @(negedge clk);
        @(negedge clk);
        checkOutput($sformatf("%s_c4@%06h", pfx, a), rdata4, e4);
        checkOutput($sformatf("%s_c2@%06h", pfx, a), rdata2, e2);
    endtask

    // Write on the cycle right after the read must not disturb it.
    task automatic readThenWrite(input string pfx, input logic [23:0] a, input logic [31:0] d);
        logic [31:0] e4;
        logic [31:0] e2;
        e4 = modelRead(0, a);
        e2 = modelRead(1, a);
        applyStimulus(1'b0, 1'b1, a, 32'h0);
        applyStimulus(1'b1, 1'b0, a, d);
        modelWrite(a, d);
        @(negedge clk);
        checkOutput($sformatf("%s_c4@%06h", pfx, a), rdata4, e4);
        checkOutput($sformatf("%s_c2@%06h", pfx, a), rdata2, e2);
    endtask

    task automatic sweep(input string pfx);
        for (int a = 0; a < MDL_SIZE; a++) begin
            busRead(pfx, 24'(a));
        end
    endtask

    initial begin
        logic [23:0] a;
        logic [31:0] d;
        int          op;

        aliasPool[0] = 24'h10_0000;
        aliasPool[1] = 24'h80_0001;
        aliasPool[2] = 24'hFF_FFFF;
        aliasPool[3] = 24'h00_0108;
        aliasPool[4] = 24'h01_0020;

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < MDL_SIZE; i++) mdl[w][i] = 32'h0;
        end
        modelReset();

        // Reset state and release.
        repeat (3) @(negedge clk);
        checkOutput("rst_rdata_c4", rdata4, 32'h0);
        checkOutput("rst_rdata_c2", rdata2, 32'h0);
        rstN = 1'b1;
        repeat (4) @(negedge clk);

        // Post-reset values.
        busRead("post_rst", 24'h00);
        busRead("post_rst", 24'h01);
        for (int i = 4; i < 8; i++) busRead("post_rst", 24'(i));

        // Two passes with no writes in between.
        sweep("pass1");
        sweep("pass2");

        // Directed pattern fill and readback.
        busWrite(24'h00, 32'hCC);
        busWrite(24'h01, 32'h01);
        for (int i = 0; i < 4; i++) busWrite(24'(4 + i), 32'(4 + i));
        for (int i = 0; i < 8; i++) begin
            busWrite(24'(8 + i),    32'(8'hE8 + i));
            busWrite(24'(32 + i),   32'(8'hD0 + i));
            busWrite(24'(40 + i),   32'(8'hC8 + i));
            busWrite(24'(48 + i),   32'(8'hB0 + i));
            busWrite(24'(56 + i),   32'(8'hA8 + i));
        end
        sweep("pattern");

        // Truncation to field width.
        busWrite(24'h01, 32'hFFFF_FFFF);
        busWrite(24'h0A, 32'hFFFF_FFFF);
        busRead("trunc", 24'h01);
        busRead("trunc", 24'h0A);

        // Unmapped and absent-copy addresses.
        busWrite(24'h02,     32'h1234_5678);
        busWrite(24'h10,     32'hDEAD_BEEF);
        busWrite(24'h40,     32'h0000_0055);
        busWrite(24'hFF_FFFF, 32'hFFFF_FFFF);
        busWrite(24'h06,     32'h0000_0009);
        busWrite(24'h30,     32'h0000_0077);
        busRead("unmap", 24'h02);
        busRead("unmap", 24'h10);
        busRead("unmap", 24'h40);
        busRead("unmap", 24'hFF_FFFF);
        sweep("after_unmap");

        // Read/write collisions.
        readWriteSame("rw_same", 24'h00, 32'h0000_0042);
        readWriteSame("rw_same", 24'h0C, 32'h0000_0011);
        readWriteSame("rw_same", 24'h21, 32'h0000_0093);
        readThenWrite("rd_wr", 24'h01, 32'h0000_0003);
        readThenWrite("rd_wr", 24'h3A, 32'h0000_0066);
        readThenWrite("rd_wr", 24'h05, 32'h0000_000E);
        busRead("collide_chk", 24'h00);
        busRead("collide_chk", 24'h3A);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) != 0) a = 24'($urandom_range(0, MDL_SIZE - 1));
            else                          a = aliasPool[$urandom_range(0, 4)];
            d  = $urandom;
            op = $urandom_range(0, 4);
            if (op < 2)       busWrite(a, d);
            else if (op < 4)  busRead("rand", a);
            else              readWriteSame("rand_rw", a, d);
        end

        // Reset while a read is in flight.
        busWrite(24'h00, 32'h5A);
        busRead("pre_rst", 24'h00);
        applyStimulus(1'b0, 1'b1, 24'h01, 32'h0);
        rstN = 1'b0;
        #1;
        checkOutput("inflight_rst_c4", rdata4, 32'h0);
        checkOutput("inflight_rst_c2", rdata2, 32'h0);
        modelReset();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("inflight_drop_c4", rdata4, 32'h0);
        checkOutput("inflight_drop_c2", rdata2, 32'h0);
        sweep("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have parameter FOO_COPIES, default 4, range 1..4: number of foo instances (register plus RAM).
REQ-002 The block SHALL have parameter TOP_BAZ, default 1: reset value of the top_baz register (low 4 bits used).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these ports in order:
- gb_clk  input  1  bus clock; all logic on its rising edge.
- gb_rst_n  input  1  asynchronous active-low reset.
- gb_addr  input  24  word address.
- gb_wdata  input  32  write data.
- gb_rdata  output  32  read data.
- gb_wen  input  1  write strobe, one cycle per write.
- gb_rstb  input  1  read strobe, one cycle per read.

Function
REQ-004 The block SHALL decode the following word-address map; unlisted addresses SHALL ignore writes and read 0:
- 0x00: top_reg, 8 bits, read/write.
- 0x01: top_baz, 4 bits, read/write.
- 0x04+k, k in 0..FOO_COPIES-1: top_foo_n[k], 4 bits, read/write.
- 0x08..0x0F: baz_ram, 8 entries x 8 bits, read/write.
- 0x20+8k..0x27+8k, k in 0..FOO_COPIES-1: foo_ram[k], 8 entries x 8 bits, read/write.
- Addresses of absent copies (k >= FOO_COPIES): unmapped.
REQ-005 Decode SHALL use all 24 address bits; there is no aliasing.
REQ-006 A write SHALL take effect on the rising gb_clk edge where gb_wen=1, storing gb_wdata truncated to the field width.
REQ-007 A read SHALL be captured when gb_rstb=1; gb_rdata SHALL present the zero-extended field value exactly 2 cycles after that edge and hold it until the next read completes.
REQ-008 Read latency SHALL be fixed at 2 cycles, which does not exceed the host's 3-cycle sample delay.
REQ-009 Reads SHALL be non-destructive: repeated reads return identical values.
REQ-010 When gb_wen and gb_rstb are asserted together at the same address, the read SHALL return the pre-write value.
REQ-011 A write in the cycle after a read SHALL NOT corrupt that read's pending data.
REQ-012 RAM reads SHALL be synchronous (registered address); the RAM SHALL infer as block/distributed RAM without reset.

Reset
REQ-013 While gb_rst_n=0, the block SHALL hold: top_reg=0x00, top_baz=TOP_BAZ[3:0], top_foo_n[*]=0x0, gb_rdata=0, read pipeline cleared.
REQ-014 RAM contents SHALL power up as zero and SHALL NOT be cleared by reset.
REQ-015 A read in flight when reset asserts SHALL be discarded.
REQ-016 Deassertion of reset SHALL be synchronized to gb_clk; the first access is accepted 2 cycles after deassertion.

Structure
REQ-017 A shared package top_pkg SHALL hold the bus widths (ADDR_W=24, DATA_W=32) and all base addresses and field widths of REQ-004.
REQ-018 One sub-module foo_blk SHALL implement the 8x8 RAM with its address decode, instantiated once for baz_ram and FOO_COPIES times via generate for foo_ram.
REQ-019 The read mux SHALL be a single registered case on the decoded region.

Verification
REQ-020 After reset, read 0x00, 0x01, 0x04..0x07 -> 0x00, TOP_BAZ (0x01), 0x0 x4.
REQ-021 Read all 46 mapped addresses twice with no intervening writes -> both passes return identical values.
REQ-022 Write 0xCC->0x00, 0x01->0x01, 0x04..0x07->0x04..0x07, 0xE8..0xEF->0x08..0x0F, 0xD0..0xD7->0x20..0x27, 0xC8..0xCF->0x28..0x2F, 0xB0..0xB7->0x30..0x37, 0xA8..0xAF->0x38..0x3F -> readback of each address equals the written value.
REQ-023 Write 0xFFFFFFFF to 0x01 and 0x0A -> reads 0x0000000F and 0x000000FF respectively.
REQ-024 Write then read unmapped 0x02, 0x10, 0x40, 0xFFFFFF -> read 0; no mapped location changes.
REQ-025 Set FOO_COPIES=2: read 0x06 and 0x30 -> 0; writes to them have no effect; 0x20..0x2F remain fully functional.
